// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial W-bit subtractor (a - b - bin), LSB first
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sr_q, a_sr_d;
  logic [W-1:0]   b_sr_q, b_sr_d;
  logic [W-1:0]   res_sr_q, res_sr_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           ovf_q, ovf_d;

  logic           d_bit;
  logic           br_next;

  // Full-subtractor cell on the current operand LSBs and the borrow flop
  always_comb begin
    d_bit   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  end

  // Next-state and datapath: capture on accepted start, shift one bit per RUN edge,
  // publish results only on the edge that enters DONE
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[W-1:1]};
        b_sr_d   = {1'b0, b_sr_q[W-1:1]};
        res_sr_d = {d_bit, res_sr_q[W-1:1]};
        br_d     = br_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          diff_d  = {d_bit, res_sr_q[W-1:1]};
          bout_d  = br_next;
          // Final result MSB is the bit just computed
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, allowing back-to-back operations
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          br_d     = bin;
          cnt_d    = '0;
          a_msb_d  = a[W-1];
          b_msb_d  = b[W-1];
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int done_cnt = 0;

  logic [W-1:0] old_diff = '0;
  logic         old_bout = 1'b0;
  logic         old_ovf  = 1'b0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int u;
    int s;
    int sa;
    int sb;
    u  = int'(ia) - int'(ib) - int'(ibin);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    s  = sa - sb - int'(ibin);
    ed = u[W-1:0];
    eb = (u < 0);
    eo = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endtask

  // Issue one operation from an idle/done cycle and check every cycle to completion.
  // If inj_k > 0, a junk start is pulsed before processing edge inj_k (must be ignored).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input int inj_k);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(ia, ib, ibin, ed, eb, eo);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    accepted++;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);
    for (int k = 1; k <= W; k++) begin
      if (inj_k > 0 && k == inj_k) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (k < W) begin
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        chk("diff_hold", diff, old_diff);
        chk("bout_hold", bout, old_bout);
        chk("ovf_hold", ovf, old_ovf);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("diff", diff, ed);
        chk("bout", bout, eb);
        chk("ovf", ovf, eo);
      end
    end
    old_diff = ed; old_bout = eb; old_ovf = eo;
  endtask

  initial begin
    int gap;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h35, 8'h12, 1'b0, 0);
    chk("d35_12", diff, 8'h23);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    chk("d00_01", {ovf, bout, diff}, {1'b0, 1'b1, 8'hFF});
    run_op(8'h10, 8'h10, 1'b1, 0);
    chk("d10_10_bin", {ovf, bout, diff}, {1'b0, 1'b1, 8'hFF});
    run_op(8'h80, 8'h01, 1'b0, 0);
    chk("d80_01", {ovf, bout, diff}, {1'b1, 1'b0, 8'h7F});
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    chk("d7F_FF", {ovf, bout, diff}, {1'b1, 1'b1, 8'h80});
    @(posedge clk); #1;

    // Junk start 3 cycles after acceptance must be ignored, then back-to-back start
    run_op(8'h55, 8'h11, 1'b0, 3);
    chk("ignored_start", diff, 8'h44);
    run_op(8'h09, 8'h03, 1'b0, 0);
    chk("back_to_back", diff, 8'h06);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 0);
    chk("arst_ovf", ovf, 0);
    gap = done_cnt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_no_done", done_cnt, gap);
    old_diff = '0; old_bout = 1'b0; old_ovf = 1'b0;
    run_op(8'hF0, 8'h0F, 1'b0, 0);
    chk("after_rst", diff, 8'hE1);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    chk("done_count", done_cnt, accepted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
